// File: rtl/i2s_pkg.sv
// Shared I2S definitions: FSM states, default widths and LRCLK slot polarity.
package i2s_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

    localparam int unsigned AUDIO_DW_DEFAULT = 16;
    localparam int unsigned SLOT_W_DEFAULT   = 8;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_if.sv
// Serial input side and parallel sample output side of the I2S receiver.
interface i2s_rx_if
    import i2s_pkg::*;
#(
    parameter int unsigned AUDIO_DW = AUDIO_DW_DEFAULT,
    parameter int unsigned SLOT_W   = SLOT_W_DEFAULT
);

    logic                i_rx_lrclk;
    logic                i_rx_sdata;
    logic [SLOT_W-1:0]   i_rx_slot_len;
    logic [AUDIO_DW-1:0] o_rx_left_chan;
    logic [AUDIO_DW-1:0] o_rx_right_chan;
    logic                o_rx_valid;
    logic                o_rx_frame_err;

    // Source of the serial stream; consumer of the samples.
    modport master (
        output i_rx_lrclk,
        output i_rx_sdata,
        output i_rx_slot_len,
        input  o_rx_left_chan,
        input  o_rx_right_chan,
        input  o_rx_valid,
        input  o_rx_frame_err
    );

    // The receiver itself.
    modport slave (
        input  i_rx_lrclk,
        input  i_rx_sdata,
        input  i_rx_slot_len,
        output o_rx_left_chan,
        output o_rx_right_chan,
        output o_rx_valid,
        output o_rx_frame_err
    );

endinterface

// File: rtl/i2s_rx_shift.sv
// Slot deserialiser: shifter, saturating bit counter, left alignment and length check.
module i2s_rx_shift
    import i2s_pkg::*;
#(
    parameter int unsigned AUDIO_DW = AUDIO_DW_DEFAULT,
    parameter int unsigned SLOT_W   = SLOT_W_DEFAULT
) (
    input  logic                i_rx_sclk,
    input  logic                i_tx_rst_n,
    input  logic                clr,
    input  logic                sdata,
    input  logic [SLOT_W-1:0]   slot_len,
    output logic [AUDIO_DW-1:0] word_c,
    output logic                len_err_c
);

    localparam logic [SLOT_W-1:0] CNT_MAX = '1;

    logic [AUDIO_DW-1:0] shift_q;
    logic [AUDIO_DW-1:0] shift_nxt;
    logic [SLOT_W-1:0]   cnt_q;
    logic [SLOT_W-1:0]   cnt_nxt;
    logic [31:0]         cap;

    // Next shifter/count including the current bit, and the word as committed now.
    always_comb begin
        shift_nxt = shift_q;
        if (32'(cnt_q) < AUDIO_DW) begin
            shift_nxt = {shift_q[AUDIO_DW-2:0], sdata};
        end
        cnt_nxt   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + SLOT_W'(1);
        cap       = (32'(cnt_nxt) < AUDIO_DW) ? 32'(cnt_nxt) : 32'(AUDIO_DW);
        word_c    = shift_nxt << (32'(AUDIO_DW) - cap);
        len_err_c = (cnt_nxt != slot_len);
    end

    // Capture state; cleared while unsynchronised and at every slot commit.
    always_ff @(posedge i_rx_sclk or negedge i_tx_rst_n) begin
        if (!i_tx_rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clr) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// Philips-format I2S slave receiver producing one stereo pair per frame.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned AUDIO_DW = AUDIO_DW_DEFAULT,
    parameter int unsigned SLOT_W   = SLOT_W_DEFAULT
) (
    input  logic    i_rx_sclk,
    input  logic    i_tx_rst_n,
    i2s_rx_if.slave rx
);

    i2s_state_e          state_q;
    logic                lrclk_d;
    logic                lr_edge_c;
    logic                shift_clr_c;
    logic [AUDIO_DW-1:0] word_c;
    logic                len_err_c;
    logic [AUDIO_DW-1:0] hold_q;
    logic [AUDIO_DW-1:0] left_q;
    logic [AUDIO_DW-1:0] right_q;
    logic                valid_q;
    logic                err_q;

    // An LRCLK change seen at this posedge marks the end of the current slot.
    assign lr_edge_c   = (rx.i_rx_lrclk != lrclk_d);
    assign shift_clr_c = (state_q == SYNC) || lr_edge_c;

    i2s_rx_shift #(
        .AUDIO_DW (AUDIO_DW),
        .SLOT_W   (SLOT_W)
    ) u_shift (
        .i_rx_sclk  (i_rx_sclk),
        .i_tx_rst_n (i_tx_rst_n),
        .clr        (shift_clr_c),
        .sdata      (rx.i_rx_sdata),
        .slot_len   (rx.i_rx_slot_len),
        .word_c     (word_c),
        .len_err_c  (len_err_c)
    );

    // Frame FSM with edge-detect register, left holding register and output registers.
    always_ff @(posedge i_rx_sclk or negedge i_tx_rst_n) begin
        if (!i_tx_rst_n) begin
            state_q <= SYNC;
            lrclk_d <= 1'b0;
            hold_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            lrclk_d <= rx.i_rx_lrclk;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                SYNC: begin
                    if (lr_edge_c && (rx.i_rx_lrclk == LR_LEFT)) begin
                        state_q <= LEFT;
                    end
                end
                LEFT: begin
                    if (lr_edge_c) begin
                        hold_q  <= word_c;
                        err_q   <= len_err_c;
                        state_q <= RIGHT;
                    end
                end
                RIGHT: begin
                    if (lr_edge_c) begin
                        left_q  <= hold_q;
                        right_q <= word_c;
                        valid_q <= 1'b1;
                        err_q   <= len_err_c;
                        state_q <= LEFT;
                    end
                end
                default: begin
                    state_q <= SYNC;
                end
            endcase
        end
    end

    assign rx.o_rx_left_chan  = left_q;
    assign rx.o_rx_right_chan = right_q;
    assign rx.o_rx_valid      = valid_q;
    assign rx.o_rx_frame_err  = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: Philips streams built from frame lists, checked against a slot-level model.
module tb_i2s_rx;

    localparam int unsigned DW = 16;
    localparam int unsigned SW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    i2s_rx_if #(.AUDIO_DW(DW), .SLOT_W(SW)) bus ();

    i2s_rx #(.AUDIO_DW(DW), .SLOT_W(SW)) dut (
        .i_rx_sclk  (clk),
        .i_tx_rst_n (rst_n),
        .rx         (bus)
    );

    int tests = 0;
    int fails = 0;

    // Observed pulses, collected by the monitor.
    int          cyc = 0;
    logic [15:0] vl_q[$];
    logic [15:0] vr_q[$];
    int          vcyc_q[$];
    int          ecyc_q[$];
    int          nz_pre = 0;
    bit          seen_v = 1'b0;

    // Frames to transmit: word and bit count per slot.
    logic [31:0] fr_lw[$];
    logic [31:0] fr_rw[$];
    int          fr_lb[$];
    int          fr_rb[$];

    // Reference: a b-bit slot value taken as a binary fraction, expressed in DW bits.
    function automatic logic [15:0] align(input logic [31:0] w, input int b);
        logic [47:0] t;
        t = {w, 16'h0000};
        t = t >> b;
        return t[15:0];
    endfunction

    function automatic logic [31:0] rand_word(input int b);
        logic [31:0] m;
        m = (b >= 32) ? 32'hFFFF_FFFF : ((32'd1 << b) - 32'd1);
        return $urandom & m;
    endfunction

    // Monitor: sample registered outputs on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.o_rx_valid === 1'b1) begin
                vl_q.push_back(bus.o_rx_left_chan);
                vr_q.push_back(bus.o_rx_right_chan);
                vcyc_q.push_back(cyc);
                seen_v = 1'b1;
            end
            if (bus.o_rx_frame_err === 1'b1) ecyc_q.push_back(cyc);
            if (!seen_v && (bus.o_rx_left_chan !== 16'h0 || bus.o_rx_right_chan !== 16'h0)) nz_pre++;
        end
    end

    // Drive: optional reset, a discarded left stub and right preamble, the frames, then a left trailer.
    task automatic run_stream(input int sl, input bit do_rst);
        bit lr_q[$];
        bit b_q[$];
        bus.i_rx_slot_len = SW'(sl);
        if (do_rst) begin
            @(negedge clk);
            rst_n = 1'b0;
            bus.i_rx_lrclk = 1'b1;
            bus.i_rx_sdata = 1'b0;
            repeat (2) @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin lr_q.push_back(1'b0); b_q.push_back(1'($urandom)); end
        for (int i = 0; i < 3; i++) begin lr_q.push_back(1'b1); b_q.push_back(1'($urandom)); end
        for (int f = 0; f < fr_lw.size(); f++) begin
            for (int k = fr_lb[f] - 1; k >= 0; k--) begin lr_q.push_back(1'b0); b_q.push_back(fr_lw[f][k]); end
            for (int k = fr_rb[f] - 1; k >= 0; k--) begin lr_q.push_back(1'b1); b_q.push_back(fr_rw[f][k]); end
        end
        for (int i = 0; i < 3; i++) begin lr_q.push_back(1'b0); b_q.push_back(1'($urandom)); end
        for (int i = 0; i < lr_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                rst_n = 1'b1;
                vl_q.delete(); vr_q.delete(); vcyc_q.delete(); ecyc_q.delete();
                nz_pre = 0;
                seen_v = 1'b0;
            end
            bus.i_rx_lrclk = lr_q[i];
            bus.i_rx_sdata = (i == 0) ? 1'($urandom) : b_q[i-1];
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_rx_lrclk = 1'b0;
        bus.i_rx_sdata = 1'b0;
        bus.i_rx_slot_len = SW'(16);
        repeat (3) @(negedge clk);
        tests++; if (bus.o_rx_left_chan !== 16'h0) begin fails++; $display("FAIL reset_left got=%h want=0000", bus.o_rx_left_chan); end
        tests++; if (bus.o_rx_right_chan !== 16'h0) begin fails++; $display("FAIL reset_right got=%h want=0000", bus.o_rx_right_chan); end
        tests++; if (bus.o_rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", bus.o_rx_valid); end
        tests++; if (bus.o_rx_frame_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", bus.o_rx_frame_err); end
    endtask

    // Matched, long and short slots with fixed known words.
    task automatic test_slot_lengths();
        int          sl_t[3] = '{16, 24, 8};
        logic [31:0] lw_t[3] = '{32'h0000_A5C3, 32'h00AB_CDEF, 32'h0000_00AB};
        logic [31:0] rw_t[3] = '{32'h0000_1234, 32'h0012_3456, 32'h0000_005C};
        logic [15:0] el_t[3] = '{16'hA5C3, 16'hABCD, 16'hAB00};
        logic [15:0] er_t[3] = '{16'h1234, 16'h1234, 16'h5C00};
        for (int t = 0; t < 3; t++) begin
            fr_lw.delete(); fr_rw.delete(); fr_lb.delete(); fr_rb.delete();
            fr_lw.push_back(lw_t[t]); fr_lb.push_back(sl_t[t]);
            fr_rw.push_back(rw_t[t]); fr_rb.push_back(sl_t[t]);
            run_stream(sl_t[t], 1'b1);
            tests++;
            if (vl_q.size() != 1) begin
                fails++; $display("FAIL slot%0d_valid_count got=%0d want=1", sl_t[t], vl_q.size());
            end else begin
                tests++; if (vl_q[0] !== el_t[t]) begin fails++; $display("FAIL slot%0d_left got=%h want=%h", sl_t[t], vl_q[0], el_t[t]); end
                tests++; if (vr_q[0] !== er_t[t]) begin fails++; $display("FAIL slot%0d_right got=%h want=%h", sl_t[t], vr_q[0], er_t[t]); end
            end
            tests++; if (ecyc_q.size() != 0) begin fails++; $display("FAIL slot%0d_err_count got=%0d want=0", sl_t[t], ecyc_q.size()); end
        end
    endtask

    // 15-bit left slot against slot_len 16: error at left commit, pair still delivered.
    task automatic test_frame_err();
        fr_lw.delete(); fr_rw.delete(); fr_lb.delete(); fr_rb.delete();
        fr_lw.push_back(32'h0000_52E1); fr_lb.push_back(15);
        fr_rw.push_back(32'h0000_BEEF); fr_rb.push_back(16);
        run_stream(16, 1'b1);
        tests++; if (ecyc_q.size() != 1) begin fails++; $display("FAIL ferr_err_count got=%0d want=1", ecyc_q.size()); end
        tests++;
        if (vl_q.size() != 1) begin
            fails++; $display("FAIL ferr_valid_count got=%0d want=1", vl_q.size());
        end else begin
            tests++; if (vl_q[0] !== 16'hA5C2) begin fails++; $display("FAIL ferr_left got=%h want=a5c2", vl_q[0]); end
            tests++; if (vr_q[0] !== 16'hBEEF) begin fails++; $display("FAIL ferr_right got=%h want=beef", vr_q[0]); end
            if (ecyc_q.size() == 1) begin
                tests++;
                if (!(ecyc_q[0] < vcyc_q[0])) begin
                    fails++; $display("FAIL ferr_timing err_cyc=%0d valid_cyc=%0d want err before valid", ecyc_q[0], vcyc_q[0]);
                end
            end
        end
    endtask

    // Random slot lengths, bit counts and words over multi-frame back-to-back streams.
    task automatic test_random();
        for (int s = 0; s < 8; s++) begin
            int sl;
            int nf;
            int exp_err;
            sl = int'($urandom_range(2, 32));
            nf = int'($urandom_range(1, 4));
            exp_err = 0;
            fr_lw.delete(); fr_rw.delete(); fr_lb.delete(); fr_rb.delete();
            for (int f = 0; f < nf; f++) begin
                int lb;
                int rb;
                lb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 32)) : sl;
                rb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 32)) : sl;
                fr_lb.push_back(lb); fr_lw.push_back(rand_word(lb));
                fr_rb.push_back(rb); fr_rw.push_back(rand_word(rb));
                exp_err += (lb != sl) ? 1 : 0;
                exp_err += (rb != sl) ? 1 : 0;
            end
            run_stream(sl, 1'b1);
            tests++;
            if (vl_q.size() != nf) begin
                fails++; $display("FAIL rand%0d_valid_count got=%0d want=%0d", s, vl_q.size(), nf);
            end else begin
                for (int f = 0; f < nf; f++) begin
                    tests++;
                    if (vl_q[f] !== align(fr_lw[f], fr_lb[f])) begin
                        fails++; $display("FAIL rand%0d_left%0d got=%h want=%h", s, f, vl_q[f], align(fr_lw[f], fr_lb[f]));
                    end
                    tests++;
                    if (vr_q[f] !== align(fr_rw[f], fr_rb[f])) begin
                        fails++; $display("FAIL rand%0d_right%0d got=%h want=%h", s, f, vr_q[f], align(fr_rw[f], fr_rb[f]));
                    end
                end
            end
            tests++;
            if (ecyc_q.size() != exp_err) begin
                fails++; $display("FAIL rand%0d_err_count got=%0d want=%0d", s, ecyc_q.size(), exp_err);
            end
        end
    endtask

    // Reset asserted mid-left-slot, then resumption: nothing until a full pair after a fresh 1->0 edge.
    task automatic test_reset_mid_frame();
        logic [31:0] lw;
        logic [31:0] rw;
        fr_lw.delete(); fr_rw.delete(); fr_lb.delete(); fr_rb.delete();
        fr_lw.push_back(rand_word(16) | 32'h8000); fr_lb.push_back(16);
        fr_rw.push_back(rand_word(16) | 32'h8000); fr_rb.push_back(16);
        run_stream(16, 1'b1);
        tests++; if (vl_q.size() != 1) begin fails++; $display("FAIL mid_pre_valid_count got=%0d want=1", vl_q.size()); end
        repeat (5) begin @(negedge clk); bus.i_rx_sdata = 1'($urandom); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.o_rx_left_chan !== 16'h0) begin fails++; $display("FAIL mid_rst_left got=%h want=0000", bus.o_rx_left_chan); end
        tests++; if (bus.o_rx_right_chan !== 16'h0) begin fails++; $display("FAIL mid_rst_right got=%h want=0000", bus.o_rx_right_chan); end
        tests++; if (bus.o_rx_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got=%b want=0", bus.o_rx_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); bus.i_rx_sdata = 1'($urandom); end
        lw = rand_word(16) | 32'h1;
        rw = rand_word(16) | 32'h1;
        fr_lw.delete(); fr_rw.delete(); fr_lb.delete(); fr_rb.delete();
        fr_lw.push_back(lw); fr_lb.push_back(16);
        fr_rw.push_back(rw); fr_rb.push_back(16);
        run_stream(16, 1'b0);
        tests++; if (nz_pre != 0) begin fails++; $display("FAIL mid_outputs_before_valid nonzero_cycles=%0d want=0", nz_pre); end
        tests++;
        if (vl_q.size() != 1) begin
            fails++; $display("FAIL mid_post_valid_count got=%0d want=1", vl_q.size());
        end else begin
            tests++; if (vl_q[0] !== lw[15:0]) begin fails++; $display("FAIL mid_post_left got=%h want=%h", vl_q[0], lw[15:0]); end
            tests++; if (vr_q[0] !== rw[15:0]) begin fails++; $display("FAIL mid_post_right got=%h want=%h", vr_q[0], rw[15:0]); end
        end
        tests++; if (ecyc_q.size() != 0) begin fails++; $display("FAIL mid_post_err_count got=%0d want=0", ecyc_q.size()); end
    endtask

    initial begin
        test_reset();
        test_slot_lengths();
        test_frame_err();
        test_random();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

Philips-format I2S slave receiver: samples externally driven SCLK/LRCLK/SDATA, deserialises MSB-first left and right slots, and presents one stereo sample pair per frame with a single-cycle valid strobe. It is the capture-side counterpart to `i2s_tx` and is used for loopback and ADC/codec input. The whole block runs in the `i_rx_sclk` domain. Any crossing to a system clock is handled outside this block.

## Interface
Parameters:
- `AUDIO_DW`, default 16: sample width per channel.
- `SLOT_W`, default 8: width of the slot-length input and the internal bit counter.

Ports:
- `i_rx_sclk`, in, 1: serial bit clock. All state updates on its rising edge.
- `i_tx_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_rx_lrclk`, in, 1: word select; 0 = left slot, 1 = right slot.
- `i_rx_sdata`, in, 1: serial data, MSB first, one SCLK after the LRCLK change.
- `i_rx_slot_len`, in, SLOT_W: expected bits per slot. Must be at least 2; held static while running.
- `o_rx_left_chan`, out, AUDIO_DW: last complete left sample.
- `o_rx_right_chan`, out, AUDIO_DW: last complete right sample.
- `o_rx_valid`, out, 1: one-SCLK pulse when a new L/R pair is on the outputs.
- `o_rx_frame_err`, out, 1: one-SCLK pulse when a committed slot's bit count differs from `i_rx_slot_len`.

## Operation
- **Edge detection:** `lrclk_d` holds the previous sampled LRCLK. An edge is `i_rx_lrclk != lrclk_d` at the current posedge.
- **State SYNC** (after reset):
  - Captured bits are discarded.
  - A 0→1 LRCLK edge is ignored.
  - On a 1→0 edge, the counter and shifter are cleared and the state goes to LEFT.
- **LEFT / RIGHT, every posedge:**
  - While the bit count is below `AUDIO_DW`, shift `i_rx_sdata` into the shifter LSB.
  - The bit count increments and saturates at 2^SLOT_W−1.
- **Commit, on an LRCLK edge in LEFT or RIGHT:**
  - The bit sampled at this posedge belongs to the ending slot (the Philips one-bit delay). It is included in the shift and in the count.
  - The word is left-aligned: shifter << (`AUDIO_DW` − captured bits). Short slots are zero-padded in the LSBs; bits beyond `AUDIO_DW` are dropped.
  - If the final count ≠ `i_rx_slot_len`, pulse `o_rx_frame_err`. The word is still committed.
  - Clear the counter and shifter.
- **Transitions on commit:**
  - LEFT (edge 0→1): word goes to the left holding register; state → RIGHT.
  - RIGHT (edge 1→0): `o_rx_left_chan` ← holding register and `o_rx_right_chan` ← word, both updated together. Pulse `o_rx_valid`; state → LEFT.
- An LRCLK edge in the wrong direction for the current state cannot occur, because the edge polarity follows from the state.
- Reset values: `o_rx_left_chan` = 0, `o_rx_right_chan` = 0, `o_rx_valid` = 0, `o_rx_frame_err` = 0. Shifter, counter and holding register = 0; `lrclk_d` = 0; state = SYNC.

## Timing
- All outputs are registered.
- `o_rx_valid` and the new channel values appear after the posedge at which the right→left LRCLK edge is first sampled. Latency from the right-slot LSB bit to valid is 0 SCLK cycles after that sampling edge.
- `o_rx_valid` and `o_rx_frame_err` are high for exactly one SCLK cycle. Both may assert on the same cycle.
- Channel outputs hold their values between valid pulses.
- With a 1→0 edge in the reset-release cycle, `lrclk_d` = 0 means no edge is detected. The block waits for the next 1→0 edge.
- Reset mid-frame: immediate return to reset values and SYNC. There is no valid pulse until a full left and right pair follows the next 1→0 edge.
- A stream started mid-right-slot is ignored until the first 1→0 edge.

## Structure
- Shared package `i2s_pkg`:
  - state enum `{SYNC, LEFT, RIGHT}`
  - the `AUDIO_DW` default
  - LRCLK polarity constants (`LR_LEFT` = 0, `LR_RIGHT` = 1)
- Sub-module `i2s_rx_shift` contains the shifter, the saturating bit counter, left-alignment and the length compare. The top level holds the LRCLK edge detect, the FSM and the output registers.

## Test plan
- `slot_len` = 16, transmit L = 16'hA5C3, R = 16'h1234, Philips timing → `o_rx_valid` pulses once with exactly those values; no error.
- `slot_len` = 24, `AUDIO_DW` = 16, send L = 24'hABCDEF, R = 24'h123456 → outputs 16'hABCD / 16'h1234; no error.
- `slot_len` = 8, send L = 8'hAB, R = 8'h5C → outputs 16'hAB00 / 16'h5C00.
- `slot_len` = 16, drive a 15-bit left slot → `o_rx_frame_err` pulses at the left commit. The following valid still occurs; data is left-aligned and zero-padded.
- Start the stream mid-right-slot, then assert reset mid-left-slot → no valid before the first complete L/R pair after a 1→0 edge; all outputs 0 during and after reset until then.
